// File: rtl/lcd_text_driver_if.sv
// Signal bundle between the display-text generator, the LCD driver and the LCD pins.
// The slave side is the driver; the master side is the text source and pin observer.
interface lcd_text_driver_if;
   logic [127:0] line1;
   logic [127:0] line2;
   logic         lcd_e;
   logic         lcd_rs;
   logic         lcd_rw;
   logic [7:0]   lcd_data;
   logic         init_done;
   logic         frame_done;

   modport master (
      output line1, line2,
      input  lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done
   );

   modport slave (
      input  line1, line2,
      output lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done
   );
endinterface

// File: rtl/lcd_text_driver.sv
// HD44780 16x2 write-only driver: power-up wait, four-command init, then endless
// two-row refresh frames built from a per-frame snapshot of the text lines.
module lcd_text_driver #(
   parameter int TICK_DIV       = 50,
   parameter int POWERUP_CYC    = 750000,
   parameter int CMD_WAIT_CYC   = 2000,
   parameter int CLEAR_WAIT_CYC = 82000
) (
   input logic              clk,
   input logic              rst,
   lcd_text_driver_if.slave bus
);

   localparam int MAX_A = (TICK_DIV > POWERUP_CYC) ? TICK_DIV : POWERUP_CYC;
   localparam int MAX_B = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
   localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAX_P) + 1;

   localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] PWR_LAST   = CW'(POWERUP_CYC - 1);
   localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYC - 1);
   localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT_CYC - 1);
   localparam logic [5:0]    LAST_INIT  = 6'd3;
   localparam logic [5:0]    LAST_FRAME = 6'd33;
   localparam logic [5:0]    ROW2_CMD   = 6'd17;
   localparam logic [127:0]  SPACES     = {16{8'h20}};

   typedef enum logic [1:0] {
      ST_PWR   = 2'd0,
      ST_INIT  = 2'd1,
      ST_FRAME = 2'd2
   } top_state_t;

   typedef enum logic [1:0] {
      PH_SETUP = 2'd0,
      PH_PULSE = 2'd1,
      PH_HOLD  = 2'd2,
      PH_WAIT  = 2'd3
   } phase_t;

   top_state_t     top_r, top_s, nxt_top_s;
   phase_t         phase_r, phase_s;
   logic [CW-1:0]  cnt_r, cnt_s, wait_last_s;
   logic [5:0]     idx_r, idx_s, nxt_idx_s;
   logic [127:0]   snap1_r, snap1_s, snap2_r, snap2_s;
   logic           e_r, e_s, rs_r, rs_s, wr_rs_s;
   logic [7:0]     data_r, data_s, wr_data_s;
   logic           init_done_r, init_done_s, frame_done_r, frame_done_s;
   logic           write_end_s;

   // Column 0 sits in the top byte, so shift the wanted column up to [127:120].
   function automatic logic [7:0] col_byte(input logic [127:0] line, input logic [3:0] col);
      logic [127:0] sh;
      sh = line << {col, 3'b000};
      return sh[127:120];
   endfunction

   assign wait_last_s = ((top_r == ST_INIT) && (idx_r == LAST_INIT)) ? CLEAR_LAST : CMD_LAST;

   // Which write follows the current one.
   always_comb begin
      nxt_top_s = top_r;
      nxt_idx_s = idx_r + 6'd1;
      case (top_r)
         ST_PWR: begin
            nxt_top_s = ST_INIT;
            nxt_idx_s = 6'd0;
         end
         ST_INIT: begin
            if (idx_r == LAST_INIT) begin
               nxt_top_s = ST_FRAME;
               nxt_idx_s = 6'd0;
            end else begin
               nxt_top_s = ST_INIT;
            end
         end
         ST_FRAME: begin
            if (idx_r == LAST_FRAME) begin
               nxt_idx_s = 6'd0;
            end else begin
               nxt_idx_s = idx_r + 6'd1;
            end
         end
         default: begin
            nxt_top_s = ST_PWR;
            nxt_idx_s = 6'd0;
         end
      endcase
   end

   // RS and byte for the following write; frame data comes from the held snapshot.
   always_comb begin
      wr_rs_s   = 1'b0;
      wr_data_s = 8'h00;
      if (nxt_top_s == ST_INIT) begin
         case (nxt_idx_s)
            6'd0:    wr_data_s = 8'h38;
            6'd1:    wr_data_s = 8'h0C;
            6'd2:    wr_data_s = 8'h06;
            default: wr_data_s = 8'h01;
         endcase
      end else if (nxt_idx_s == 6'd0) begin
         wr_data_s = 8'h80;
      end else if (nxt_idx_s == ROW2_CMD) begin
         wr_data_s = 8'hC0;
      end else if (nxt_idx_s < ROW2_CMD) begin
         wr_rs_s   = 1'b1;
         wr_data_s = col_byte(snap1_r, 4'(nxt_idx_s - 6'd1));
      end else begin
         wr_rs_s   = 1'b1;
         wr_data_s = col_byte(snap2_r, 4'(nxt_idx_s - 6'd18));
      end
   end

   // Phase sequencing; a finished write loads the next one in the same cycle.
   always_comb begin
      top_s        = top_r;
      phase_s      = phase_r;
      cnt_s        = cnt_r + CNT_ONE;
      idx_s        = idx_r;
      e_s          = e_r;
      rs_s         = rs_r;
      data_s       = data_r;
      init_done_s  = init_done_r;
      frame_done_s = 1'b0;
      snap1_s      = snap1_r;
      snap2_s      = snap2_r;
      write_end_s  = 1'b0;
      case (top_r)
         ST_PWR: begin
            if (cnt_r == PWR_LAST) begin
               write_end_s = 1'b1;
            end else begin
               write_end_s = 1'b0;
            end
         end
         ST_INIT, ST_FRAME: begin
            case (phase_r)
               PH_SETUP: begin
                  if (cnt_r == TICK_LAST) begin
                     phase_s = PH_PULSE;
                     cnt_s   = CNT_ZERO;
                     e_s     = 1'b1;
                  end else begin
                     e_s     = 1'b0;
                  end
               end
               PH_PULSE: begin
                  if (cnt_r == TICK_LAST) begin
                     phase_s = PH_HOLD;
                     cnt_s   = CNT_ZERO;
                     e_s     = 1'b0;
                  end else begin
                     e_s     = 1'b1;
                  end
               end
               PH_HOLD: begin
                  if (cnt_r == TICK_LAST) begin
                     phase_s = PH_WAIT;
                     cnt_s   = CNT_ZERO;
                  end else begin
                     phase_s = PH_HOLD;
                  end
               end
               PH_WAIT: begin
                  if (cnt_r == wait_last_s) begin
                     write_end_s = 1'b1;
                  end else begin
                     write_end_s = 1'b0;
                  end
               end
               default: begin
                  phase_s = PH_SETUP;
                  cnt_s   = CNT_ZERO;
                  e_s     = 1'b0;
               end
            endcase
         end
         default: begin
            top_s = ST_PWR;
            cnt_s = CNT_ZERO;
         end
      endcase

      if (write_end_s) begin
         top_s   = nxt_top_s;
         idx_s   = nxt_idx_s;
         phase_s = PH_SETUP;
         cnt_s   = CNT_ZERO;
         e_s     = 1'b0;
         rs_s    = wr_rs_s;
         data_s  = wr_data_s;
         if ((top_r == ST_INIT) && (nxt_top_s == ST_FRAME)) begin
            init_done_s = 1'b1;
         end else begin
            init_done_s = init_done_r;
         end
         if ((top_r == ST_FRAME) && (nxt_idx_s == 6'd0)) begin
            frame_done_s = 1'b1;
         end else begin
            frame_done_s = 1'b0;
         end
         // The text for a whole frame is frozen as its first write begins.
         if ((nxt_top_s == ST_FRAME) && (nxt_idx_s == 6'd0)) begin
            snap1_s = bus.line1;
            snap2_s = bus.line2;
         end else begin
            snap1_s = snap1_r;
            snap2_s = snap2_r;
         end
      end else begin
         idx_s = idx_r;
      end
   end

   // State, counters, snapshot and registered pin outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         top_r        <= ST_PWR;
         phase_r      <= PH_SETUP;
         cnt_r        <= CNT_ZERO;
         idx_r        <= 6'd0;
         snap1_r      <= SPACES;
         snap2_r      <= SPACES;
         e_r          <= 1'b0;
         rs_r         <= 1'b0;
         data_r       <= 8'h00;
         init_done_r  <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         top_r        <= top_s;
         phase_r      <= phase_s;
         cnt_r        <= cnt_s;
         idx_r        <= idx_s;
         snap1_r      <= snap1_s;
         snap2_r      <= snap2_s;
         e_r          <= e_s;
         rs_r         <= rs_s;
         data_r       <= data_s;
         init_done_r  <= init_done_s;
         frame_done_r <= frame_done_s;
      end
   end

   assign bus.lcd_e      = e_r;
   assign bus.lcd_rs     = rs_r;
   assign bus.lcd_rw     = 1'b0;
   assign bus.lcd_data   = data_r;
   assign bus.init_done  = init_done_r;
   assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Directed bench for lcd_text_driver with small timing parameters
// (write = 10 cycles, clear = 14, init ends at cycle 54, frame = 340).
module tb_lcd_text_driver;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   int   cyc;

   localparam logic [127:0] L1 = "PRESS * TO START";
   localparam logic [127:0] L2 = "MONEY: 01000    ";
   localparam logic [127:0] LX = {16{8'h58}};

   lcd_text_driver_if bus ();

   lcd_text_driver #(
      .TICK_DIV      (2),
      .POWERUP_CYC   (10),
      .CMD_WAIT_CYC  (4),
      .CLEAR_WAIT_CYC(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index: number of rising edges seen since reset release.
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   // Recorded pin activity, cleared while reset is held.
   int         rise_cyc[$];
   logic       rise_rs[$];
   logic [7:0] rise_data[$];
   int         fd_cyc[$];
   int         ehi_q[$];
   int         ehi_len;
   int         chg_bad;
   int         rw_bad;
   logic       prev_e;
   logic [8:0] prev_bus;

   function automatic bit legal_start(input int c);
      return (c == 10) || (c == 20) || (c == 30) || (c == 40) ||
             ((c >= 54) && (((c - 54) % 10) == 0));
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         if (bus.lcd_e && !prev_e) begin
            rise_cyc.push_back(cyc);
            rise_rs.push_back(bus.lcd_rs);
            rise_data.push_back(bus.lcd_data);
         end
         if (bus.lcd_e) begin
            ehi_len <= ehi_len + 1;
         end else if (prev_e) begin
            ehi_q.push_back(ehi_len);
            ehi_len <= 0;
         end
         if (({bus.lcd_rs, bus.lcd_data} !== prev_bus) && !legal_start(cyc)) chg_bad <= chg_bad + 1;
         if (bus.lcd_rw !== 1'b0) rw_bad <= rw_bad + 1;
         if (bus.frame_done) fd_cyc.push_back(cyc);
         prev_e   <= bus.lcd_e;
         prev_bus <= {bus.lcd_rs, bus.lcd_data};
      end else begin
         rise_cyc.delete();
         rise_rs.delete();
         rise_data.delete();
         fd_cyc.delete();
         ehi_q.delete();
         ehi_len  <= 0;
         chg_bad  <= 0;
         rw_bad   <= 0;
         prev_e   <= 1'b0;
         prev_bus <= 9'd0;
      end
   end

   // Expected {rs, byte} of write k within a frame.
   function automatic logic [8:0] exp_write(input logic [127:0] a, input logic [127:0] b, input int k);
      logic [127:0] sh;
      if (k == 0)  return {1'b0, 8'h80};
      if (k == 17) return {1'b0, 8'hC0};
      if (k < 17) sh = a << (8 * (k - 1));
      else        sh = b << (8 * (k - 18));
      return {1'b1, sh[127:120]};
   endfunction

   task automatic release_rst();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_until(input int target);
      for (int g = 0; (g < 3000) && (cyc < target); g++) @(negedge clk);
      n_cmp++;
      if (cyc < target) begin
         n_bad++;
         $display("FAIL run_until: reached cycle %0d, required %0d", cyc, target);
      end
   endtask

   task automatic test_reset_hold();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.line1 = {16{8'(i)}};
         bus.line2 = ~bus.line1;
         n_cmp++;
         if ({bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data, bus.init_done, bus.frame_done} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_hold[%0d]: outputs %h, required 0", i,
                     {bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data, bus.init_done, bus.frame_done});
         end
      end
   endtask

   task automatic test_init();
      logic [7:0] cmds [4];
      cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
      bus.line1 = L1;
      bus.line2 = L2;
      release_rst();
      for (int g = 0; (g < 200) && (cyc < 60); g++) begin
         @(negedge clk);
         if (cyc <= 11) begin
            n_cmp++;
            if (bus.lcd_e !== 1'b0) begin
               n_bad++;
               $display("FAIL init_e_quiet: lcd_e=%b at cycle %0d, required 0", bus.lcd_e, cyc);
            end
         end
         if (cyc == 53) begin
            n_cmp++;
            if (bus.init_done !== 1'b0) begin
               n_bad++;
               $display("FAIL init_done_early: %b at cycle 53, required 0", bus.init_done);
            end
         end
         if (cyc == 54) begin
            n_cmp++;
            if (bus.init_done !== 1'b1) begin
               n_bad++;
               $display("FAIL init_done_rise: %b at cycle 54, required 1", bus.init_done);
            end
         end
      end
      n_cmp++;
      if (rise_cyc.size() < 4) begin
         n_bad++;
         $display("FAIL init_count: %0d E pulses, required at least 4", rise_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ((rise_cyc[i] != 12 + 10 * i) || (rise_rs[i] !== 1'b0) || (rise_data[i] !== cmds[i])) begin
               n_bad++;
               $display("FAIL init_cmd[%0d]: cyc %0d rs %b data %h, required cyc %0d rs 0 data %h",
                        i, rise_cyc[i], rise_rs[i], rise_data[i], 12 + 10 * i, cmds[i]);
            end
         end
      end
   endtask

   task automatic test_frame_text();
      int idx;
      run_until(400);
      n_cmp++;
      if (rise_cyc.size() < 38) begin
         n_bad++;
         $display("FAIL frame1_count: %0d E pulses, required at least 38", rise_cyc.size());
      end else begin
         for (int k = 0; k < 34; k++) begin
            idx = 4 + k;
            n_cmp++;
            if (({rise_rs[idx], rise_data[idx]} !== exp_write(L1, L2, k)) || (rise_cyc[idx] != 56 + 10 * k)) begin
               n_bad++;
               $display("FAIL frame1[%0d]: cyc %0d rs/data %h, required cyc %0d rs/data %h",
                        k, rise_cyc[idx], {rise_rs[idx], rise_data[idx]}, 56 + 10 * k, exp_write(L1, L2, k));
            end
         end
      end
      n_cmp++;
      if ((fd_cyc.size() < 1) || (fd_cyc[0] != 394)) begin
         n_bad++;
         $display("FAIL frame_done_1: %0d pulses, first at %0d, required first at 394",
                  fd_cyc.size(), (fd_cyc.size() > 0) ? fd_cyc[0] : -1);
      end
   endtask

   task automatic test_snapshot();
      int idx;
      logic [127:0] exp1;
      run_until(446);
      bus.line1 = LX;
      run_until(1080);
      n_cmp++;
      if (rise_cyc.size() < 106) begin
         n_bad++;
         $display("FAIL snapshot_count: %0d E pulses, required at least 106", rise_cyc.size());
      end else begin
         for (int f = 1; f < 3; f++) begin
            exp1 = (f == 1) ? L1 : LX;
            for (int k = 0; k < 34; k++) begin
               idx = 4 + 34 * f + k;
               n_cmp++;
               if (({rise_rs[idx], rise_data[idx]} !== exp_write(exp1, L2, k)) ||
                   (rise_cyc[idx] != 56 + 340 * f + 10 * k)) begin
                  n_bad++;
                  $display("FAIL snapshot_f%0d[%0d]: cyc %0d rs/data %h, required cyc %0d rs/data %h",
                           f, k, rise_cyc[idx], {rise_rs[idx], rise_data[idx]},
                           56 + 340 * f + 10 * k, exp_write(exp1, L2, k));
               end
            end
         end
      end
      n_cmp++;
      if ((fd_cyc.size() != 3) || (fd_cyc[1] != 734) || (fd_cyc[2] != 1074)) begin
         n_bad++;
         $display("FAIL frame_done_period: %0d pulses, required 3 at 394/734/1074", fd_cyc.size());
      end
   endtask

   task automatic test_write_timing();
      n_cmp++;
      if (ehi_q.size() < 106) begin
         n_bad++;
         $display("FAIL e_pulse_count: %0d, required at least 106", ehi_q.size());
      end
      foreach (ehi_q[i]) begin
         n_cmp++;
         if (ehi_q[i] != 2) begin
            n_bad++;
            $display("FAIL e_width[%0d]: %0d cycles, required 2", i, ehi_q[i]);
         end
      end
      n_cmp++;
      if (chg_bad != 0) begin
         n_bad++;
         $display("FAIL bus_stable: %0d rs/data changes outside SETUP entry, required 0", chg_bad);
      end
      n_cmp++;
      if (rw_bad != 0) begin
         n_bad++;
         $display("FAIL rw_zero: %0d cycles with lcd_rw high, required 0", rw_bad);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      release_rst();
      run_until(400);
      for (int g = 0; (g < 100) && !bus.lcd_e; g++) @(negedge clk);
      n_cmp++;
      if ((bus.lcd_e !== 1'b1) || (bus.init_done !== 1'b1)) begin
         n_bad++;
         $display("FAIL mid_pre: lcd_e %b init_done %b, required 1 1", bus.lcd_e, bus.init_done);
      end
      #3;
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data, bus.init_done, bus.frame_done} !== 13'd0) begin
         n_bad++;
         $display("FAIL mid_async: outputs %h right after reset, required 0",
                  {bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data, bus.init_done, bus.frame_done});
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.line1 = ~bus.line1;
         n_cmp++;
         if ({bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data, bus.init_done, bus.frame_done} !== 13'd0) begin
            n_bad++;
            $display("FAIL mid_hold[%0d]: outputs nonzero during reset", i);
         end
      end
      release_rst();
      for (int g = 0; (g < 50) && (cyc < 13); g++) begin
         @(negedge clk);
         if (cyc <= 11) begin
            n_cmp++;
            if (bus.lcd_e !== 1'b0) begin
               n_bad++;
               $display("FAIL restart_quiet: lcd_e=%b at cycle %0d, required 0", bus.lcd_e, cyc);
            end
         end
         if (cyc == 12) begin
            n_cmp++;
            if ({bus.lcd_e, bus.lcd_rs, bus.lcd_data} !== {1'b1, 1'b0, 8'h38}) begin
               n_bad++;
               $display("FAIL restart_first: e/rs/data %b/%b/%h at cycle 12, required 1/0/38",
                        bus.lcd_e, bus.lcd_rs, bus.lcd_data);
            end
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      bus.line1 = L1;
      bus.line2 = L2;
      test_reset_hold();
      test_init();
      test_frame_text();
      test_snapshot();
      test_write_timing();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
